fault_injector: RTL

Transmit-side counterpart of the gate fault model. It generates the `fault_in` strobes that fault-capable gate instances consume. After an arm handshake it uses a seeded 12-bit LFSR to decide, cycle by cycle, when to fire, then sends single-cycle strobes round-robin over `FAULT_COUNT` lines until the requested burst is spent. It sits beside a gate array in the fault-simulation harness, and its outputs connect one-to-one to gate `fault_in` ports.

---
 rtl/fault_injector.sv | 95 +++++++++
 1 files changed

// File: rtl/fault_injector.sv
// rtl/fault_injector.sv - LFSR-paced round-robin fault strobe generator for gate fault_in ports
module fault_injector #(
  parameter int          FAULT_COUNT = 4,
  parameter logic [11:0] RAND_SEED   = 12'hAAA
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   logic_reset,
  input  logic                   arm_valid,
  output logic                   arm_ready,
  input  logic [11:0]            rate,
  input  logic [7:0]             burst_len,
  input  logic                   abort,
  output logic [FAULT_COUNT-1:0] fault_out,
  output logic                   done,
  output logic [15:0]            inject_count
);

  localparam int              PTR_W    = (FAULT_COUNT > 1) ? $clog2(FAULT_COUNT) : 1;
  localparam logic [11:0]     SEED     = (RAND_SEED == 12'd0) ? 12'h001 : RAND_SEED;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FAULT_COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_INJECT, S_DONE} state_t;

  state_t           state, state_n;
  logic [11:0]      lfsr;
  logic [11:0]      rate_q;
  logic [7:0]       remaining;
  logic [PTR_W-1:0] ptr;
  logic [15:0]      inject_count_q;
  logic             lfsr_fb;

  assign lfsr_fb = lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else if (logic_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (arm_valid) state_n = S_ARMED;
      S_ARMED: begin
        if (abort)                state_n = S_DONE;
        else if (lfsr <= rate_q)  state_n = S_INJECT;
      end
      S_INJECT: begin
        if (abort || remaining == 8'd1) state_n = S_DONE;
        else                            state_n = S_ARMED;
      end
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // The LFSR free-runs in every state so the firing pattern depends only on time since load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr           <= SEED;
      rate_q         <= 12'd0;
      remaining      <= 8'd0;
      ptr            <= '0;
      inject_count_q <= 16'd0;
    end else if (logic_reset) begin
      lfsr           <= SEED;
      rate_q         <= 12'd0;
      remaining      <= 8'd0;
      ptr            <= '0;
      inject_count_q <= 16'd0;
    end else begin
      lfsr <= {lfsr[10:0], lfsr_fb};
      if (state == S_IDLE && arm_valid) begin
        rate_q    <= rate;
        remaining <= (burst_len == 8'd0) ? 8'd1 : burst_len;
      end
      if (state == S_INJECT) begin
        ptr       <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
        remaining <= remaining - 8'd1;
        if (inject_count_q != 16'hFFFF) inject_count_q <= inject_count_q + 16'd1;
      end
    end
  end

  assign arm_ready    = (state == S_IDLE);
  assign done         = (state == S_DONE);
  assign inject_count = inject_count_q;
  assign fault_out    = (state == S_INJECT) ? (FAULT_COUNT'(1) << ptr) : '0;

endmodule
